// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester (P, D) and memory-side signals for mem_port_arbiter.
// slave = arbiter side, master = the environment driving requests and memory data.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Handshake: a requester raises req with its fields and keeps them steady until its
  // one-cycle ack; err/rdata are valid with ack and stay held until that port's next ack.
  logic              i_p_req;
  logic              i_p_we;
  logic [ADDR_W-1:0] i_p_addr;
  logic [DATA_W-1:0] i_p_wdata;
  logic              o_p_ack;
  logic              o_p_err;
  logic [DATA_W-1:0] o_p_rdata;

  logic              i_d_req;
  logic              i_d_we;
  logic [ADDR_W-1:0] i_d_addr;
  logic [DATA_W-1:0] i_d_wdata;
  logic              o_d_ack;
  logic              o_d_err;
  logic [DATA_W-1:0] o_d_rdata;

  logic [ADDR_W-1:0] o_mem_address;
  logic [DATA_W-1:0] o_mem_data;
  logic              o_mem_enable_read;
  logic              o_mem_enable_write;
  logic [DATA_W-1:0] i_mem_data;
  logic              o_busy;

  modport slave (
    input  i_p_req, i_p_we, i_p_addr, i_p_wdata,
    output o_p_ack, o_p_err, o_p_rdata,
    input  i_d_req, i_d_we, i_d_addr, i_d_wdata,
    output o_d_ack, o_d_err, o_d_rdata,
    output o_mem_address, o_mem_data, o_mem_enable_read, o_mem_enable_write,
    input  i_mem_data,
    output o_busy
  );

  modport master (
    output i_p_req, i_p_we, i_p_addr, i_p_wdata,
    input  o_p_ack, o_p_err, o_p_rdata,
    output i_d_req, i_d_we, i_d_addr, i_d_wdata,
    input  o_d_ack, o_d_err, o_d_rdata,
    input  o_mem_address, o_mem_data, o_mem_enable_read, o_mem_enable_write,
    output i_mem_data,
    input  o_busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester (P over D) arbiter for a single-ported memory stage: IDLE -> ISSUE -> RESP.
// Optional D anti-starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 128
`ifdef ARB_STARVE_GUARD_EN
  ,
  parameter int MAX_WAIT  = 4
`endif
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            state;
  logic              owner_d;
  logic              we_q;
  logic              oor_q;
  logic              p_ack_q, p_err_q, d_ack_q, d_err_q;
  logic [DATA_W-1:0] p_rdata_q, d_rdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_data_q;
  logic              rd_q, wr_q, busy_q;

  logic              any_req;
  logic              starve;
  logic              grant_d;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_in_range;
  logic              rd_pass;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  logic [CNT_W-1:0] wait_cnt;
  assign starve = (wait_cnt == CNT_W'(MAX_WAIT));
`else
  assign starve = 1'b0;
`endif

  always_comb begin
    any_req      = bus.i_p_req | bus.i_d_req;
    grant_d      = bus.i_d_req & (~bus.i_p_req | starve);
    sel_we       = grant_d ? bus.i_d_we    : bus.i_p_we;
    sel_addr     = grant_d ? bus.i_d_addr  : bus.i_p_addr;
    sel_wdata    = grant_d ? bus.i_d_wdata : bus.i_p_wdata;
    sel_in_range = (sel_addr < ADDR_W'(MEM_DEPTH));
  end

  // Memory read data arrives during RESP, so in-range reads bypass it straight to the owner.
  assign rd_pass = (state == RESP) & ~we_q & ~oor_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner_d    <= 1'b0;
      we_q       <= 1'b0;
      oor_q      <= 1'b0;
      p_ack_q    <= 1'b0;
      p_err_q    <= 1'b0;
      d_ack_q    <= 1'b0;
      d_err_q    <= 1'b0;
      p_rdata_q  <= '0;
      d_rdata_q  <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      wait_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state   <= ISSUE;
            busy_q  <= 1'b1;
            owner_d <= grant_d;
            we_q    <= sel_we;
            oor_q   <= ~sel_in_range;
            if (sel_in_range) begin
              mem_addr_q <= sel_addr;
              mem_data_q <= sel_wdata;
              rd_q       <= ~sel_we;
              wr_q       <= sel_we;
            end
`ifdef ARB_STARVE_GUARD_EN
            // D losing to P can only happen below MAX_WAIT, so the count saturates there.
            if (grant_d)
              wait_cnt <= '0;
            else if (bus.i_d_req)
              wait_cnt <= wait_cnt + 1'b1;
`endif
          end
        end
        ISSUE: begin
          state <= RESP;
          rd_q  <= 1'b0;
          wr_q  <= 1'b0;
          if (owner_d) begin
            d_ack_q   <= 1'b1;
            d_err_q   <= oor_q;
            d_rdata_q <= '0;
          end else begin
            p_ack_q   <= 1'b1;
            p_err_q   <= oor_q;
            p_rdata_q <= '0;
          end
        end
        RESP: begin
          state   <= IDLE;
          busy_q  <= 1'b0;
          p_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          if (rd_pass) begin
            if (owner_d) d_rdata_q <= bus.i_mem_data;
            else         p_rdata_q <= bus.i_mem_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_p_ack            = p_ack_q;
  assign bus.o_p_err            = p_err_q;
  assign bus.o_p_rdata          = (rd_pass & ~owner_d) ? bus.i_mem_data : p_rdata_q;
  assign bus.o_d_ack            = d_ack_q;
  assign bus.o_d_err            = d_err_q;
  assign bus.o_d_rdata          = (rd_pass & owner_d) ? bus.i_mem_data : d_rdata_q;
  assign bus.o_mem_address      = mem_addr_q;
  assign bus.o_mem_data         = mem_data_q;
  assign bus.o_mem_enable_read  = rd_q;
  assign bus.o_mem_enable_write = wr_q;
  assign bus.o_busy             = busy_q;
  assign state_dbg              = state;

endmodule
